// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: one 32-bit word per line, 1-cycle hits,
// single-word refill from the memory controller, and redirect handling via if_clear.
module icache_direct #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_read_flag,
    input  logic [ADDR_WIDTH-1:0] if_read_address,
    input  logic                  if_clear,
    output logic                  icache_flag,
    output logic [31:0]           icache_instruction,
    output logic                  instruction_read_flag,
    output logic [ADDR_WIDTH-1:0] instruction_read_address,
    input  logic                  instruction_flag,
    input  logic [31:0]           instruction
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [31:0]             data_q [LINES];
    logic                    flag_q, flag_d;
    logic [31:0]             instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;

    logic [INDEX_BITS-1:0]   req_idx, miss_idx;
    logic [TAG_W-1:0]        req_tag, miss_tag;
    logic                    hit, accept, fill;
    logic                    unused_addr_bits;

    assign req_idx  = if_read_address[INDEX_BITS+1:2];
    assign req_tag  = if_read_address[ADDR_WIDTH-1:INDEX_BITS+2];
    assign miss_idx = miss_addr_q[INDEX_BITS+1:2];
    assign miss_tag = miss_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_addr_bits = ^{if_read_address[1:0], miss_addr_q[1:0]};

    assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // The flag_q gate stops IF's still-held request from being taken twice.
    assign accept = (state_q == IDLE) && if_read_flag && !if_clear && !flag_q;
    assign fill   = (state_q != IDLE) && instruction_flag;

    assign icache_flag              = flag_q;
    assign icache_instruction       = instr_q;
    assign instruction_read_address = miss_addr_q;

    always_comb begin
        state_d               = state_q;
        flag_d                = 1'b0;
        instr_d               = instr_q;
        miss_addr_d           = miss_addr_q;
        instruction_read_flag = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        flag_d  = 1'b1;
                        instr_d = data_q[req_idx];
                    end else begin
                        miss_addr_d = {if_read_address[ADDR_WIDTH-1:2], 2'b00};
                        state_d     = MISS;
                    end
                end
            end
            MISS: begin
                // Dropped in the response cycle so the controller never sees a repeat request.
                instruction_read_flag = !instruction_flag;
                if (instruction_flag) begin
                    state_d = IDLE;
                    if (!if_clear) begin
                        flag_d  = 1'b1;
                        instr_d = instruction;
                    end
                end else if (if_clear) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                instruction_read_flag = !instruction_flag;
                if (instruction_flag) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            flag_q      <= 1'b0;
            instr_q     <= 32'd0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            instr_q     <= instr_d;
            miss_addr_q <= miss_addr_d;
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= instruction;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: a line-level model (which address each line
// holds) predicts hits/misses; a negedge monitor checks every icache_flag pulse.
module tb_icache_direct;
    logic        clk;
    logic        rst;
    logic        if_read_flag;
    logic [31:0] if_read_address;
    logic        if_clear;
    logic        icache_flag;
    logic [31:0] icache_instruction;
    logic        instruction_read_flag;
    logic [31:0] instruction_read_address;
    logic        instruction_flag;
    logic [31:0] instruction;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic        mvalid [256];
    logic [31:0] maddr [256];
    logic        prev_flag;

    icache_direct #(.INDEX_BITS(8), .ADDR_WIDTH(32)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .if_read_flag             (if_read_flag),
        .if_read_address          (if_read_address),
        .if_clear                 (if_clear),
        .icache_flag              (icache_flag),
        .icache_instruction       (icache_instruction),
        .instruction_read_flag    (instruction_read_flag),
        .instruction_read_address (instruction_read_address),
        .instruction_flag         (instruction_flag),
        .instruction              (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0400: return 32'h0010_0093;
            32'h0000_0008: return 32'hFE01_0113;
            default:       return (a * 32'h9E37_79B1) + 32'h0123_4567;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Monitor: every pulse must match the oldest expected word, and pulses never abut.
    always @(negedge clk) begin
        if (!rst && icache_flag === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse got=%h required=no_pulse", icache_instruction);
            end else begin
                chk("pulse_data", icache_instruction, exp_q.pop_front());
            end
            chk("pulse_width", {31'd0, prev_flag}, 32'd0);
        end
        prev_flag = (icache_flag === 1'b1);
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        exp_q.delete();
        chk("rst_flag", icache_flag, 0);
        chk("rst_instr", icache_instruction, 0);
        chk("rst_req", instruction_read_flag, 0);
        chk("rst_addr", instruction_read_address, 0);
    endtask

    // clr: 0 none, 1 redirect while controller busy, 2 redirect in the response cycle
    task automatic fetch(input logic [31:0] addr, input int busy, input int clr);
        logic [31:0] a;
        int          idx;
        bit          hit;
        a   = {addr[31:2], 2'b00};
        idx = int'(a[9:2]);
        hit = mvalid[idx] && (maddr[idx] == a);
        if_read_flag    = 1'b1;
        if_read_address = addr;
        if (hit) exp_q.push_back(mem_word(a));
        @(posedge clk); #1;
        chk("miss_req", {31'd0, instruction_read_flag}, {31'd0, !hit});
        if (hit) begin
            chk("hit_latency", icache_flag, 1);
        end else begin
            chk("miss_addr", instruction_read_address, a);
            for (int i = 0; i < busy; i++) begin
                if (clr == 1 && i == busy - 1) begin
                    if_clear     = 1'b1;
                    if_read_flag = 1'b0;
                end
                @(posedge clk); #1;
                if_clear = 1'b0;
                chk("busy_hold", instruction_read_flag, 1);
            end
            instruction_flag = 1'b1;
            instruction      = mem_word(a);
            if (clr == 2) begin
                if_clear     = 1'b1;
                if_read_flag = 1'b0;
            end
            #1;
            chk("req_drop", instruction_read_flag, 0);
            if (clr == 0) exp_q.push_back(mem_word(a));
            @(posedge clk); #1;
            instruction_flag = 1'b0;
            instruction      = $urandom;
            if_clear         = 1'b0;
            mvalid[idx]      = 1'b1;
            maddr[idx]       = a;
            chk("fill_pulse", {31'd0, icache_flag}, (clr == 0) ? 32'd1 : 32'd0);
            chk("no_refetch", instruction_read_flag, 0);
        end
        @(posedge clk); #1;
        if_read_flag = 1'b0;
    endtask

    task automatic cleared_req(input logic [31:0] addr);
        if_read_flag    = 1'b1;
        if_read_address = addr;
        if_clear        = 1'b1;
        @(posedge clk); #1;
        if_clear     = 1'b0;
        if_read_flag = 1'b0;
        chk("clr_idle_flag", icache_flag, 0);
        chk("clr_idle_req", instruction_read_flag, 0);
    endtask

    task automatic stray_response();
        instruction_flag = 1'b1;
        instruction      = $urandom;
        @(posedge clk); #1;
        instruction_flag = 1'b0;
        chk("stray_flag", icache_flag, 0);
        chk("stray_req", instruction_read_flag, 0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        prev_flag        = 1'b0;
        rst              = 1'b1;
        if_read_flag     = 1'b0;
        if_read_address  = 32'd0;
        if_clear         = 1'b0;
        instruction_flag = 1'b0;
        instruction      = 32'd0;
        @(posedge clk); #1;
        do_reset();

        fetch(32'h0000_0000, 0, 0);   // cold miss
        fetch(32'h0000_0000, 0, 0);   // hit
        fetch(32'h0000_0400, 2, 0);   // conflict evicts index 0
        fetch(32'h0000_0003, 1, 0);   // misses again, low bits ignored
        fetch(32'h0000_0010, 20, 0);  // busy controller
        fetch(32'h0000_0008, 3, 1);   // redirect during miss
        fetch(32'h0000_0008, 0, 0);   // hits with drained fill
        fetch(32'h0000_000C, 2, 2);   // redirect in response cycle
        fetch(32'h0000_000C, 0, 0);
        cleared_req(32'h0000_0008);
        stray_response();
        fetch(32'h0000_0010, 0, 0);

        do_reset();                   // invalidation
        fetch(32'h0000_0000, 1, 0);

        if_read_flag    = 1'b1;       // reset in the middle of a miss
        if_read_address = 32'h0000_0020;
        @(posedge clk); #1;
        chk("mid_miss_req", instruction_read_flag, 1);
        if_read_flag = 1'b0;
        do_reset();
        fetch(32'h0000_0020, 0, 0);

        for (int n = 0; n < 400; n++) begin
            int          r, tsel, busy, clr;
            logic [21:0] hi;
            logic [31:0] addr;
            r    = $urandom_range(0, 9);
            tsel = $urandom_range(0, 3);
            hi   = (tsel == 3) ? 22'h3F_FFFF : 22'(tsel);
            addr = {hi, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (r == 0) begin
                cleared_req(addr);
            end else if (r == 1) begin
                stray_response();
            end else begin
                busy = $urandom_range(0, 4);
                r    = $urandom_range(0, 9);
                clr  = (r == 8) ? 1 : (r == 9) ? 2 : 0;
                if (clr == 1 && busy == 0) busy = 1;
                fetch(addr, busy, clr);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pending_pulses", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory controller.
- Services fetch requests from local storage on a hit.
- On a miss it issues one word request to the memory controller, fills the line, then answers fetch.
- Supports a fetch clear (branch redirect) that discards an in-flight miss result for IF but still fills the line.

Parameters:
INDEX_BITS, 8, log2 of line count (one 32-bit instruction per line); tag = address[31:INDEX_BITS+2]
ADDR_WIDTH, 32, instruction address width

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  reset, synchronous, active-high
if_read_flag  input  1  IF requests the instruction at if_read_address; held until icache_flag
if_read_address  input  32  fetch address, word aligned (bits[1:0] ignored)
if_clear  input  1  redirect; abandon current request, result must not reach IF
icache_flag  output  1  registered one-cycle pulse: icache_instruction valid
icache_instruction  output  32  instruction for the last accepted request
instruction_read_flag  output  1  word fetch request to memory controller (combinational)
instruction_read_address  output  32  address of that request (registered miss address)
instruction_flag  input  1  memory controller one-cycle pulse: instruction valid
instruction  input  32  fetched word from memory controller

Behaviour:
- Storage: valid[2^INDEX_BITS], tag array, data array; index = addr[INDEX_BITS+1:2].
- Reset (synchronous, active-high): all valid bits cleared in one cycle; state=IDLE; icache_flag=0; icache_instruction=0; miss address=0; instruction_read_flag=0.
- States: IDLE, MISS, DRAIN.
- IDLE:
  - Request accepted when if_read_flag=1, if_clear=0 and icache_flag=0. The icache_flag=0 gate blocks re-acceptance of the request IF still holds during the response cycle.
  - Hit (valid and tag match): next cycle icache_flag=1, icache_instruction=data. Hit latency is 1 cycle; state stays IDLE.
  - Miss: latch the aligned address ({addr[31:2],2'b00}) into the miss address; go to MISS. No output pulse.
- MISS:
  - instruction_read_flag = 1 while instruction_flag=0.
  - It is forced low in the cycle instruction_flag=1, so the memory controller, which samples on return to idle, sees no duplicate request.
  - The request is held indefinitely while the memory controller serves loads/stores.
  - On instruction_flag=1: write valid/tag/data at the miss index; icache_flag=1 and icache_instruction=instruction next cycle; go to IDLE.
  - if_clear=1 with instruction_flag=0: go to DRAIN.
  - if_clear=1 in the same cycle as instruction_flag=1: fill the line, no icache_flag, go to IDLE.
- DRAIN:
  - Request stays asserted under the same rule as MISS; if_clear is ignored.
  - On instruction_flag=1: fill the line, no icache_flag, go to IDLE.
  - if_read_flag is ignored in DRAIN; IF re-presents after the clear.
- if_clear in IDLE suppresses acceptance that cycle and cancels a hit pulse scheduled for the next cycle.
- icache_flag is never high for two consecutive cycles. icache_instruction holds its value between pulses.
- Reset mid-miss: immediate return to IDLE with all lines invalid. The memory controller shares rst, so no response is outstanding.
- instruction_flag outside MISS/DRAIN is ignored.

Test Plan:
- Cold miss: reset; IF requests 0x00000000. Required: instruction_read_flag=1, address 0x00000000. Mem returns 0x00000013. Required: next cycle icache_flag pulse with 0x00000013, then instruction_read_flag low.
- Hit: re-request 0x00000000. Required: icache_flag one cycle later with 0x00000013; instruction_read_flag stays 0.
- Conflict (INDEX_BITS=8): fill 0x00000000 (0x00000013), then miss on 0x00000400 (0x00100093). Required: a re-request of 0x00000000 misses again and issues instruction_read_flag.
- Busy controller: hold instruction_flag low for 20 cycles after a miss. Required: instruction_read_flag stays high throughout and drops in the instruction_flag cycle; exactly one fill occurs.
- Clear during miss: miss on 0x00000008, assert if_clear, mem returns 0xFE010113. Required: no icache_flag. A later request to 0x00000008 hits in 1 cycle with 0xFE010113.
- Reset invalidation: after fills, pulse rst. Required: a request to 0x00000000 misses; all outputs are 0 in the cycle after reset.
